// File: rtl/layer_input_streamer.sv
// Buffers one input vector from the loader and broadcasts it to a layer's neurons.
// The vector is sent one sample per cycle after a short lead-in, then the block waits for the layer result.
module layer_input_streamer #(
  parameter int numInputs     = 256,
  parameter int dataWidth     = 16,
  parameter int leadCycles    = 1,
  parameter int timeoutCycles = 1024
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [dataWidth-1:0] loadData,
  input  logic                 loadValid,
  output logic                 loadReady,
  input  logic                 start,
  output logic                 bufFull,
  output logic [dataWidth-1:0] neuronIn,
  output logic                 neuronValid,
  input  logic                 resultValid,
  output logic                 layerDone,
  output logic                 busy,
  output logic                 timeoutErr
);

  localparam int PW = $clog2(numInputs + 1);
  localparam int AW = (numInputs > 1) ? $clog2(numInputs) : 1;
  localparam int TW = (timeoutCycles > 1) ? $clog2(timeoutCycles) : 1;

  localparam logic [PW-1:0] LAST_IDX = PW'(numInputs - 1);
  localparam logic [2:0]    LEAD     = 3'(leadCycles);
  localparam logic [TW-1:0] TO_LAST  = TW'(timeoutCycles - 1);

  typedef enum logic [2:0] {
    S_LOAD,
    S_FULL,
    S_STREAM,
    S_WAIT,
    S_DONE
  } state_e;

  state_e                 state_q, state_d;
  logic [PW-1:0]          wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]          rd_ptr_q, rd_ptr_d;
  logic [2:0]             lead_cnt_q, lead_cnt_d;
  logic [TW-1:0]          to_cnt_q, to_cnt_d;
  logic                   timeout_err_q, timeout_err_d;
  logic [dataWidth-1:0]   neuron_in_q, neuron_in_d;
  logic                   wr_en;

  logic [dataWidth-1:0]   buf_mem [numInputs];

  // NOTE: every signal assigned in always_comb gets a default first, so no path can infer a latch.
  always_comb begin
    state_d       = state_q;
    wr_ptr_d      = wr_ptr_q;
    rd_ptr_d      = rd_ptr_q;
    lead_cnt_d    = lead_cnt_q;
    to_cnt_d      = to_cnt_q;
    timeout_err_d = timeout_err_q;
    wr_en         = 1'b0;

    unique case (state_q)
      S_LOAD: begin
        if (loadValid) begin
          wr_en    = 1'b1;
          wr_ptr_d = wr_ptr_q + PW'(1);
          if (wr_ptr_q == LAST_IDX) state_d = S_FULL;
        end
      end
      S_FULL: begin
        if (start) begin
          state_d    = S_STREAM;
          rd_ptr_d   = '0;
          lead_cnt_d = '0;
          to_cnt_d   = '0;
        end
      end
      S_STREAM: begin
        // rd_ptr_q indexes the sample currently on neuronIn once the lead-in is over.
        if (lead_cnt_q < LEAD) begin
          lead_cnt_d = lead_cnt_q + 3'd1;
        end else if (rd_ptr_q == LAST_IDX) begin
          state_d = S_WAIT;
        end else begin
          rd_ptr_d = rd_ptr_q + PW'(1);
        end
      end
      S_WAIT: begin
        to_cnt_d = to_cnt_q + TW'(1);
        if (resultValid) begin
          state_d = S_DONE;
        end else if (to_cnt_q == TO_LAST) begin
          timeout_err_d = 1'b1;
          state_d       = S_DONE;
        end
      end
      S_DONE: begin
        wr_ptr_d = '0;
        state_d  = S_LOAD;
      end
      default: state_d = S_LOAD;
    endcase
  end

  // neuronIn is registered, so the next-cycle sample is chosen from the next-cycle pointers.
  always_comb begin
    neuron_in_d = '0;
    if ((state_d == S_STREAM) && (lead_cnt_d == LEAD)) begin
      neuron_in_d = buf_mem[rd_ptr_d[AW-1:0]];
    end
  end

  // NOTE: sequential state uses non-blocking assignments so all flops update together on the edge.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q       <= S_LOAD;
      wr_ptr_q      <= '0;
      rd_ptr_q      <= '0;
      lead_cnt_q    <= '0;
      to_cnt_q      <= '0;
      timeout_err_q <= 1'b0;
      neuron_in_q   <= '0;
    end else begin
      state_q       <= state_d;
      wr_ptr_q      <= wr_ptr_d;
      rd_ptr_q      <= rd_ptr_d;
      lead_cnt_q    <= lead_cnt_d;
      to_cnt_q      <= to_cnt_d;
      timeout_err_q <= timeout_err_d;
      neuron_in_q   <= neuron_in_d;
    end
  end

  // NOTE: the sample buffer has no reset; stale contents are always overwritten before being read.
  always_ff @(posedge clk) begin
    if (wr_en) buf_mem[wr_ptr_q[AW-1:0]] <= loadData;
  end

  assign loadReady   = (state_q == S_LOAD);
  assign bufFull     = (state_q == S_FULL);
  assign neuronValid = (state_q == S_STREAM);
  assign busy        = (state_q == S_STREAM) || (state_q == S_WAIT);
  assign layerDone   = (state_q == S_DONE);
  assign timeoutErr  = timeout_err_q;
  assign neuronIn    = neuron_in_q;

endmodule
